// File: rtl/serial_tc_decoder.sv
// Bit-serial two's-complement to sign-magnitude decoder, LSB first.
// Magnitude is rebuilt on the fly: copy bits through the first 1, invert the rest.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; bit_valid ignored
// SHIFT | accepting WIDTH bits on bit_valid, gaps allowed
// DONE  | one-cycle result strobe; start and bit_valid ignored
module serial_tc_decoder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic             busy,
    output logic             done,
    output logic             sign,
    output logic [WIDTH-1:0] mag
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] neg;
    logic [CW-1:0]    count;
    logic             seen_one;

    logic [WIDTH-1:0] raw_nxt;
    logic [WIDTH-1:0] neg_nxt;
    logic             last_bit;

    assign raw_nxt  = {bit_in, raw[WIDTH-1:1]};
    assign neg_nxt  = {(seen_one ? ~bit_in : bit_in), neg[WIDTH-1:1]};
    assign last_bit = (count == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            raw      <= '0;
            neg      <= '0;
            count    <= '0;
            seen_one <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sign     <= 1'b0;
            mag      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state    <= SHIFT;
                        raw      <= '0;
                        neg      <= '0;
                        count    <= '0;
                        seen_one <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (bit_valid) begin
                        raw      <= raw_nxt;
                        neg      <= neg_nxt;
                        seen_one <= seen_one | bit_in;
                        count    <= count + 1'b1;
                        // Result is registered on the accepting edge so it is
                        // already valid during the DONE cycle.
                        if (last_bit) begin
                            state <= DONE;
                            done  <= 1'b1;
                            sign  <= raw_nxt[WIDTH-1];
                            mag   <= raw_nxt[WIDTH-1] ? neg_nxt : raw_nxt;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
